max_score_tracker: RTL and testbench
====================================

Name: max_score_tracker

Overview:
- Sits directly downstream of the myMax64 reduction tree, which turns the 64 PE V-outputs into one per-column maximum with a 2-cycle register latency.
- Aligns raw column-valid/last strobes with that delayed result and keeps the running best score and its column across one query pass.
- Drives the reduction tree's init.
- Hands {score, column} to the result path on a valid/ready handshake.

Parameters:
- DATA_WIDTH, `V_E_F_Bit (18): score width; MSB is the sign bit.
- COL_WIDTH, `Max_T_size_log (13): column index width.
- LATENCY, 2: cycles from column strobe to the matching max_in (myMax64 depth); legal range 1..4.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active-low
- start  in  1  begin a new pass (accepted only in IDLE)
- col_valid  in  1  PE array produced a column this cycle
- col_last  in  1  qualifies col_valid: final column of the pass
- max_in  in  DATA_WIDTH  myMax64 result, valid LATENCY cycles after col_valid
- max_init  out  1  drives myMax64 init
- busy  out  1  state != IDLE
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_score  out  DATA_WIDTH  best score of the pass
- out_col  out  COL_WIDTH  column index (0-based) of best score

Behaviour:
- Reset: state=IDLE; delay line cleared; best=0; best_col=0; col_cnt=0.
- Reset values of outputs: max_init=1, busy=0, out_valid=0, out_score=0, out_col=0.
- States are IDLE, RUN, DRAIN and DONE.
- IDLE:
  - max_init=1; col_valid ignored.
  - start=1 -> RUN; clears best, best_col and col_cnt; clears the delay line.
- RUN:
  - max_init=0.
  - col_valid pushes {valid, last} into a LATENCY-deep shift register; the tap emits d_valid/d_last aligned with max_in.
  - col_valid&col_last -> DRAIN; strobes after that cycle are ignored, i.e. not pushed.
- DRAIN:
  - Continue shifting zeros in.
  - On d_valid&d_last, do the final compare -> DONE.
- Every d_valid (RUN or DRAIN) does three things:
  - Sanitise: s = max_in[MSB] ? 0 : max_in.
  - If s > best (strictly, unsigned on DATA_WIDTH-1 bits): best<=s, best_col<=col_cnt. Ties keep the earlier column.
  - col_cnt <= col_cnt+1, saturating at all-ones; it does not wrap.
- DONE:
  - out_valid=1; out_score=best and out_col=best_col, held stable.
  - out_ready=1 -> IDLE; out_valid drops the next cycle.
  - max_init=1 in DONE.
- Latency: out_valid rises the cycle after the last column's d_valid, i.e. LATENCY+1 cycles after the col_last strobe.
- start outside IDLE is ignored, including in the DONE cycle where out_ready=1; it must be re-asserted in IDLE.
- col_valid&col_last in the same cycle as the start acceptance is ignored; the first column may come the cycle after.
- Zero-column pass is not supported; the upstream always sends at least one column.
- out_score/out_col retain their last values in IDLE; they are only meaningful while out_valid=1.
- Mid-pass rst_n assertion aborts immediately to the reset values; there is no partial result.

Optional Feature:
- Macro: MAX_TRACKER_THRESH_EN.
- When defined, the block adds:
  - input thresh[DATA_WIDTH-1:0], sampled at start acceptance.
  - outputs hit (1) and hit_col (COL_WIDTH).
- hit sets on the first d_valid with s >= thresh and latches col_cnt into hit_col.
- Both clear at start acceptance and are reported alongside out_valid.
- When undefined, these ports and their logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared header already holds `V_E_F_Bit and `Max_T_size_log.
- Add there: `MAXTRK_LATENCY (2), kept equal to the myMax64 depth, plus the state encoding localparams.
- One natural sub-module: strobe_delay. It is a parameterised LATENCY-deep {valid, last} shift register with synchronous clear, reusable for other alignment needs.

Test Plan:
- Basic pass: start, then 5 columns with max_in sequence 3,9,4,9,1 (delayed 2 cycles), last on col 4 -> out_valid 3 cycles after last strobe, out_score=9, out_col=1 (tie keeps earlier).
- Negative clamp: all max_in=18'h20005 (MSB set) over 3 columns -> out_score=0, out_col=0.
- Backpressure: out_ready held low 10 cycles in DONE -> out_valid, out_score and out_col stable; ready=1 -> IDLE next cycle, max_init=1; start in that ready cycle ignored.
- Gapped strobes: col_valid with bubbles (1,0,0,1,1), values 2,7,5 -> out_score=7, out_col=1, confirming the column count ignores bubbles.
- Reset mid-DRAIN: rst_n low 1 cycle -> busy=0, out_valid=0, max_init=1; new pass then yields a correct fresh result.
- MAX_TRACKER_THRESH_EN: thresh=6, values 2,7,8 -> hit=1, hit_col=1, out_score=8, out_col=2.

Source files
------------

// File: rtl/max_score_tracker_pkg.sv
// Shared definitions for the max score tracker: data widths, reduction-tree latency, FSM encoding.
// Optional threshold reporting is enabled with the MAX_TRACKER_THRESH_EN macro (see max_score_tracker).
package max_score_tracker_pkg;

  localparam int V_E_F_BIT      = 18;
  localparam int MAX_T_SIZE_LOG = 13;

  // Must track the register depth of the myMax64 reduction tree.
  localparam int MAXTRK_LATENCY = 2;

  localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
  localparam logic [1:0] ST_RUN_ENC   = 2'd1;
  localparam logic [1:0] ST_DRAIN_ENC = 2'd2;
  localparam logic [1:0] ST_DONE_ENC  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = ST_IDLE_ENC,
    ST_RUN   = ST_RUN_ENC,
    ST_DRAIN = ST_DRAIN_ENC,
    ST_DONE  = ST_DONE_ENC
  } state_t;

endpackage

// File: rtl/max_score_tracker_strobe_delay.sv
// LATENCY-deep {valid, last} shift register with synchronous clear; the tap lines a strobe
// up with a datapath result that arrives LATENCY cycles later.
module strobe_delay #(
  parameter int LATENCY = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic in_valid,
  input  logic in_last,
  output logic out_valid,
  output logic out_last
);

  logic [LATENCY-1:0] valid_sr;
  logic [LATENCY-1:0] last_sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_sr <= '0;
      last_sr  <= '0;
    end else if (clr) begin
      valid_sr <= '0;
      last_sr  <= '0;
    end else begin
      // last is stored pre-qualified so the tap never shows a stray last without valid
      valid_sr[0] <= in_valid;
      last_sr[0]  <= in_valid & in_last;
      for (int i = 1; i < LATENCY; i++) begin
        valid_sr[i] <= valid_sr[i-1];
        last_sr[i]  <= last_sr[i-1];
      end
    end
  end

  assign out_valid = valid_sr[LATENCY-1];
  assign out_last  = last_sr[LATENCY-1];

endmodule

// File: rtl/max_score_tracker.sv
// Tracks the best per-column score (and its column) over one query pass downstream of myMax64.
// Define MAX_TRACKER_THRESH_EN to add threshold-hit reporting (thresh, hit, hit_col).
module max_score_tracker
  import max_score_tracker_pkg::*;
#(
  parameter int DATA_WIDTH = V_E_F_BIT,
  parameter int COL_WIDTH  = MAX_T_SIZE_LOG,
  parameter int LATENCY    = MAXTRK_LATENCY
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  col_valid,
  input  logic                  col_last,
  input  logic [DATA_WIDTH-1:0] max_in,
  output logic                  max_init,
  output logic                  busy,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_score,
  output logic [COL_WIDTH-1:0]  out_col,
`ifdef MAX_TRACKER_THRESH_EN
  input  logic [DATA_WIDTH-1:0] thresh,
  output logic                  hit,
  output logic [COL_WIDTH-1:0]  hit_col,
`endif
  output logic [1:0]            state_dbg
);

  // Result handshake: out_valid rises on DONE entry and stays high with out_score/out_col
  // frozen until the cycle out_ready is sampled high; a transfer happens on valid & ready.

  state_t                state;
  logic [DATA_WIDTH-1:0] best;
  logic [COL_WIDTH-1:0]  best_col;
  logic [COL_WIDTH-1:0]  col_cnt;

  logic                  accept_start;
  logic                  push;
  logic                  d_valid;
  logic                  d_last;
  logic [DATA_WIDTH-1:0] score_s;
  logic                  take;
  logic [DATA_WIDTH-1:0] best_nxt;
  logic [COL_WIDTH-1:0]  best_col_nxt;

  assign accept_start = (state == ST_IDLE) && start;
  assign push         = (state == ST_RUN) && col_valid;
  assign state_dbg    = state;

  strobe_delay #(
    .LATENCY (LATENCY)
  ) u_strobe_delay (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (accept_start),
    .in_valid  (push),
    .in_last   (col_last),
    .out_valid (d_valid),
    .out_last  (d_last)
  );

  always_comb begin
    // Negative maxima are clamped to zero; a strictly larger score is needed to move the best,
    // so ties keep the earlier column.
    score_s      = max_in[DATA_WIDTH-1] ? '0 : max_in;
    take         = d_valid && (score_s[DATA_WIDTH-2:0] > best[DATA_WIDTH-2:0]);
    best_nxt     = take ? score_s : best;
    best_col_nxt = take ? col_cnt : best_col;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      best      <= '0;
      best_col  <= '0;
      col_cnt   <= '0;
      max_init  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_score <= '0;
      out_col   <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_RUN;
            best     <= '0;
            best_col <= '0;
            col_cnt  <= '0;
            max_init <= 1'b0;
            busy     <= 1'b1;
          end
        end
        ST_RUN, ST_DRAIN: begin
          if (d_valid) begin
            best     <= best_nxt;
            best_col <= best_col_nxt;
            if (col_cnt != '1) col_cnt <= col_cnt + 1'b1;
          end
          if ((state == ST_RUN) && col_valid && col_last) state <= ST_DRAIN;
          if (d_valid && d_last) begin
            state     <= ST_DONE;
            out_valid <= 1'b1;
            out_score <= best_nxt;
            out_col   <= best_col_nxt;
            max_init  <= 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef MAX_TRACKER_THRESH_EN
  logic [DATA_WIDTH-1:0] thresh_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      thresh_q <= '0;
      hit      <= 1'b0;
      hit_col  <= '0;
    end else if (accept_start) begin
      thresh_q <= thresh;
      hit      <= 1'b0;
      hit_col  <= '0;
    end else if (((state == ST_RUN) || (state == ST_DRAIN)) && d_valid && !hit &&
                 (score_s >= thresh_q)) begin
      hit     <= 1'b1;
      hit_col <= col_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_max_score_tracker.sv
// Self-checking bench for max_score_tracker: directed and randomized passes against a reference model.
module tb_max_score_tracker;
  import max_score_tracker_pkg::*;

  localparam int DW   = 18;
  localparam int CW   = 13;
  localparam int LAT  = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          col_valid;
  logic          col_last;
  logic [DW-1:0] max_in;
  logic          max_init;
  logic          busy;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_score;
  logic [CW-1:0] out_col;
  logic [1:0]    state_dbg;
`ifdef MAX_TRACKER_THRESH_EN
  logic [DW-1:0] thresh;
  logic          hit;
  logic [CW-1:0] hit_col;
`endif

  int tests = 0;
  int fails = 0;

  // Upstream stand-in: values wait here until myMax64 would present them
  logic [DW-1:0] pipe_v  [LAT];
  logic          pipe_ok [LAT];

  logic [DW-1:0] col_vals [$];
  int            gaps     [$];
  int            e_score, e_col, e_hcol;
  logic          e_hit;

  max_score_tracker dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .col_valid (col_valid),
    .col_last  (col_last),
    .max_in    (max_in),
    .max_init  (max_init),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_score (out_score),
    .out_col   (out_col),
`ifdef MAX_TRACKER_THRESH_EN
    .thresh    (thresh),
    .hit       (hit),
    .hit_col   (hit_col),
`endif
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_pipe();
    for (int i = 0; i < LAT; i++) begin
      pipe_v[i]  = '0;
      pipe_ok[i] = 1'b0;
    end
  endtask

  // One clock: drive strobes now, present the value pushed LAT cycles ago, sample #1 after the edge
  task automatic step(input logic cv, input logic cl, input logic [DW-1:0] v, input logic push);
    col_valid = cv;
    col_last  = cl;
    max_in    = pipe_ok[LAT-1] ? pipe_v[LAT-1] : DW'($urandom);
    for (int i = LAT - 1; i > 0; i--) begin
      pipe_v[i]  = pipe_v[i-1];
      pipe_ok[i] = pipe_ok[i-1];
    end
    pipe_v[0]  = v;
    pipe_ok[0] = push & cv;
    @(posedge clk);
    #1;
  endtask

  task automatic model(input logic [DW-1:0] th);
    int s, c;
    e_score = 0;
    e_col   = 0;
    e_hit   = 1'b0;
    e_hcol  = 0;
    for (int i = 0; i < col_vals.size(); i++) begin
      s = col_vals[i][DW-1] ? 0 : int'(col_vals[i]);
      c = (i > CMAX) ? CMAX : i;
      if (s > e_score) begin
        e_score = s;
        e_col   = c;
      end
      if (!e_hit && s >= int'(th)) begin
        e_hit  = 1'b1;
        e_hcol = c;
      end
    end
  endtask

  task automatic send_columns();
    for (int i = 0; i < col_vals.size(); i++) begin
      for (int g = 0; g < gaps[i]; g++) step(1'b0, 1'($urandom), DW'($urandom), 1'b0);
      step(1'b1, (i == col_vals.size() - 1), col_vals[i], 1'b1);
    end
  endtask

  task automatic begin_pass(input logic [DW-1:0] th);
    model(th);
`ifdef MAX_TRACKER_THRESH_EN
    thresh = th;
`endif
    start = 1'b1;
    // a strobe coincident with start acceptance must be dropped
    step(1'b1, 1'b1, DW'($urandom), 1'b0);
    start = 1'b0;
`ifdef MAX_TRACKER_THRESH_EN
    thresh = DW'($urandom);
`endif
    check("busy_run", busy, 1);
    check("init_run", max_init, 0);
    check("state_run", state_dbg, ST_RUN);
  endtask

  task automatic run_pass(input logic [DW-1:0] th, input int hold);
    begin_pass(th);
    send_columns();
    for (int k = 0; k < LAT; k++) begin
      check("early_valid", out_valid, 0);
      step(1'($urandom), 1'($urandom), DW'($urandom), 1'b0);
    end
    check("out_valid", out_valid, 1);
    check("out_score", out_score, e_score);
    check("out_col", out_col, e_col);
    check("init_done", max_init, 1);
    check("state_done", state_dbg, ST_DONE);
`ifdef MAX_TRACKER_THRESH_EN
    check("hit", hit, e_hit);
    if (e_hit) check("hit_col", hit_col, e_hcol);
`endif
    for (int k = 0; k < hold; k++) begin
      start = 1'($urandom);
      step(1'($urandom), 1'($urandom), DW'($urandom), 1'b0);
      check("hold_valid", out_valid, 1);
      check("hold_score", out_score, e_score);
      check("hold_col", out_col, e_col);
    end
    out_ready = 1'b1;
    start     = 1'b1;
    step(1'b0, 1'b0, '0, 1'b0);
    out_ready = 1'b0;
    start     = 1'b0;
    check("valid_drop", out_valid, 0);
    check("busy_idle", busy, 0);
    check("init_idle", max_init, 1);
    check("state_idle", state_dbg, ST_IDLE);
    step(1'b1, 1'b1, '0, 1'b0);
    check("start_in_done_ignored", busy, 0);
    check("idle_keeps_score", out_score, e_score);
  endtask

  task automatic set_cols3(input int a, input int b, input int c);
    col_vals = {};
    gaps     = {};
    col_vals.push_back(DW'(a)); col_vals.push_back(DW'(b)); col_vals.push_back(DW'(c));
    gaps.push_back(0); gaps.push_back(0); gaps.push_back(0);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    col_valid = 1'b0;
    col_last  = 1'b0;
    max_in    = '0;
    out_ready = 1'b0;
`ifdef MAX_TRACKER_THRESH_EN
    thresh    = '0;
`endif
    clear_pipe();
    repeat (3) @(posedge clk);
    #1;
    check("rst_init", max_init, 1);
    check("rst_busy", busy, 0);
    check("rst_valid", out_valid, 0);
    check("rst_score", out_score, 0);
    check("rst_col", out_col, 0);
    check("rst_state", state_dbg, ST_IDLE);
    rst_n = 1'b1;
    step(1'b1, 1'b1, '0, 1'b0);
    check("idle_ignores_col", busy, 0);

    // basic pass, tie keeps the earlier column
    col_vals = {};
    gaps     = {};
    foreach (col_vals[i]) gaps.push_back(0);
    col_vals.push_back(18'd3); col_vals.push_back(18'd9); col_vals.push_back(18'd4);
    col_vals.push_back(18'd9); col_vals.push_back(18'd1);
    for (int i = 0; i < 5; i++) gaps.push_back(0);
    run_pass(18'd100, 0);
    check("basic_score_const", out_score, 9);
    check("basic_col_const", out_col, 1);

    // negative clamp
    set_cols3('h20005, 'h20005, 'h20005);
    run_pass(18'd1, 0);

    // backpressure
    set_cols3(5, 11, 2);
    run_pass(18'd3, 10);

    // gapped strobes 1,0,0,1,1
    set_cols3(2, 7, 5);
    gaps[1] = 2;
    run_pass(18'd50, 2);

    // threshold pass
    set_cols3(2, 7, 8);
    run_pass(18'd6, 1);

    // reset mid-drain, then a fresh pass
    set_cols3(4, 30, 6);
    begin_pass(18'd0);
    send_columns();
    step(1'b0, 1'b0, '0, 1'b0);
    check("drain_state", state_dbg, ST_DRAIN);
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_valid", out_valid, 0);
    check("abort_init", max_init, 1);
    check("abort_state", state_dbg, ST_IDLE);
    check("abort_score", out_score, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_pipe();
    set_cols3(12, 3, 15);
    run_pass(18'd13, 0);

    // column counter saturates instead of wrapping
    col_vals = {};
    gaps     = {};
    for (int i = 0; i < CMAX + 5; i++) begin
      col_vals.push_back((i == CMAX + 3) ? 18'd100 : 18'd1);
      gaps.push_back(0);
    end
    run_pass(18'd100, 0);

    // randomized passes
    for (int p = 0; p < 12; p++) begin
      int n;
      n = $urandom_range(1, 10);
      col_vals = {};
      gaps     = {};
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) col_vals.push_back({1'b1, 17'($urandom)});
        else col_vals.push_back(DW'($urandom_range(0, 40)));
        gaps.push_back($urandom_range(0, 2));
      end
      run_pass(DW'($urandom_range(0, 40)), $urandom_range(0, 4));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
